pipeline_hazard_ctrl: RTL and testbench

Central hazard and stall controller for the five-stage RV32I pipeline. It generates the `bubble*` (hold) and `flush*` (clear) controls for the IF/ID/EX/MEM/WB segment registers. It handles load-use interlocks, control-transfer flushes and multi-cycle data-memory misses through a small stall FSM with a post-refill hold counter. It also keeps two wrap-around performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32I pipeline: segment-register bubble/flush controls plus stall/flush counters.
// Latency: controls are combinational from state and inputs; counters update on the edge after the qualifying cycle.
// Backpressure: a data-memory miss freezes IF..MEM (WB flushed) until refill plus HOLD_CYCLES; load-use inserts one bubble.
module pipeline_hazard_ctrl #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic        rs1_used_D,
  input  logic        rs2_used_D,
  input  logic [4:0]  reg_dest_E,
  input  logic        load_E,
  input  logic        br_E,
  input  logic        jalr_E,
  input  logic        jal_D,
  input  logic        mem_req_M,
  input  logic        mem_ready,
  output logic        bubbleF,
  output logic        flushF,
  output logic        bubbleD,
  output logic        flushD,
  output logic        bubbleE,
  output logic        flushE,
  output logic        bubbleM,
  output logic        flushM,
  output logic        bubbleW,
  output logic        flushW,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Post-refill hold is skipped entirely when HOLD_CYCLES is zero.
  localparam logic       HOLD_EN   = (HOLD_CYCLES != 0);
  localparam logic [3:0] HOLD_INIT = HOLD_EN ? 4'(HOLD_CYCLES - 1) : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] hold_left, hold_left_nxt;
  logic       mem_stall;
  logic       load_use;
  logic       rule_stall;
  logic       rule_flush;

  // State and hold counter registers; reset abandons any miss in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_left <= 4'd0;
    end else begin
      state     <= state_nxt;
      hold_left <= hold_left_nxt;
    end
  end

  // Miss FSM next-state: IDLE -> MISS on a miss, MISS -> HOLD/IDLE on refill, HOLD counts down.
  always_comb begin
    state_nxt     = state;
    hold_left_nxt = hold_left;
    case (state)
      IDLE: begin
        if (mem_req_M && !mem_ready) state_nxt = MISS;
      end
      MISS: begin
        if (mem_ready) begin
          if (HOLD_EN) begin
            state_nxt     = HOLD;
            hold_left_nxt = HOLD_INIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        if (hold_left == 4'd0) state_nxt = IDLE;
        else                   hold_left_nxt = hold_left - 4'd1;
      end
      default: begin
        state_nxt     = IDLE;
        hold_left_nxt = 4'd0;
      end
    endcase
  end

  // Hazard detection: memory freeze covers the detecting cycle, the miss, and the hold window.
  always_comb begin
    mem_stall = ((state == IDLE) && mem_req_M && !mem_ready) ||
                ((state == MISS) && !(mem_ready && !HOLD_EN)) ||
                (state == HOLD);
    load_use  = load_E && (reg_dest_E != 5'd0) &&
                ((rs1_used_D && (rs1_D == reg_dest_E)) ||
                 (rs2_used_D && (rs2_D == reg_dest_E)));
  end

  // Prioritised segment controls: mem freeze > redirect in EX > load-use > jal in ID.
  always_comb begin
    bubbleF    = 1'b0;
    flushF     = 1'b0;
    bubbleD    = 1'b0;
    flushD     = 1'b0;
    bubbleE    = 1'b0;
    flushE     = 1'b0;
    bubbleM    = 1'b0;
    flushM     = 1'b0;
    bubbleW    = 1'b0;
    flushW     = 1'b0;
    rule_stall = 1'b0;
    rule_flush = 1'b0;
    if (!rst_n) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (mem_stall) begin
      bubbleF    = 1'b1;
      bubbleD    = 1'b1;
      bubbleE    = 1'b1;
      bubbleM    = 1'b1;
      flushW     = 1'b1;
      rule_stall = 1'b1;
    end else if (br_E || jalr_E) begin
      flushD     = 1'b1;
      flushE     = 1'b1;
      rule_flush = 1'b1;
    end else if (load_use) begin
      bubbleF    = 1'b1;
      bubbleD    = 1'b1;
      flushE     = 1'b1;
      rule_stall = 1'b1;
    end else if (jal_D) begin
      flushD     = 1'b1;
      rule_flush = 1'b1;
    end
  end

  // Wrap-around performance counters for stalled and redirect-flushed cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (rule_stall) stall_cnt <= stall_cnt + 32'd1;
      if (rule_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (HOLD_CYCLES=1 and 0) share stimulus.
// Controls are sampled 1ns after inputs change on the falling edge; counters 1ns after the rising edge.
// Expected control vectors are hand-written per step; expected counters follow from those vectors.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_D, rs2_D, reg_dest_E;
  logic        rs1_used_D, rs2_used_D, load_E, br_E, jalr_E, jal_D, mem_req_M, mem_ready;

  logic        bF1, fF1, bD1, fD1, bE1, fE1, bM1, fM1, bW1, fW1;
  logic        bF0, fF0, bD0, fD0, bE0, fE0, bM0, fM0, bW0, fW0;
  logic [31:0] scnt1, fcnt1, scnt0, fcnt0;

  // {bubbleF,flushF,bubbleD,flushD,bubbleE,flushE,bubbleM,flushM,bubbleW,flushW}
  localparam logic [9:0] CTL_NONE = 10'b00_00_00_00_00;
  localparam logic [9:0] CTL_MEM  = 10'b10_10_10_10_01;
  localparam logic [9:0] CTL_BR   = 10'b00_01_01_00_00;
  localparam logic [9:0] CTL_LU   = 10'b10_10_01_00_00;
  localparam logic [9:0] CTL_JAL  = 10'b00_01_00_00_00;
  localparam logic [9:0] CTL_RST  = 10'b00_01_01_01_01;

  logic [9:0]  ctl1, ctl0;
  logic [31:0] es1, ef1, es0, ef0;
  int          checks = 0;
  int          errors = 0;

  assign ctl1 = {bF1, fF1, bD1, fD1, bE1, fE1, bM1, fM1, bW1, fW1};
  assign ctl0 = {bF0, fF0, bD0, fD0, bE0, fE0, bM0, fM0, bW0, fW0};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.HOLD_CYCLES(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .reg_dest_E(reg_dest_E),
    .load_E(load_E), .br_E(br_E), .jalr_E(jalr_E), .jal_D(jal_D),
    .mem_req_M(mem_req_M), .mem_ready(mem_ready),
    .bubbleF(bF1), .flushF(fF1), .bubbleD(bD1), .flushD(fD1), .bubbleE(bE1),
    .flushE(fE1), .bubbleM(bM1), .flushM(fM1), .bubbleW(bW1), .flushW(fW1),
    .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  pipeline_hazard_ctrl #(.HOLD_CYCLES(0)) u_h0 (
    .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .reg_dest_E(reg_dest_E),
    .load_E(load_E), .br_E(br_E), .jalr_E(jalr_E), .jal_D(jal_D),
    .mem_req_M(mem_req_M), .mem_ready(mem_ready),
    .bubbleF(bF0), .flushF(fF0), .bubbleD(bD0), .flushD(fD0), .bubbleE(bE0),
    .flushE(fE0), .bubbleM(bM0), .flushM(fM0), .bubbleW(bW0), .flushW(fW0),
    .stall_cnt(scnt0), .flush_cnt(fcnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [4:0] dest, input logic [4:0] r1,
                       input logic u1, input logic [4:0] r2, input logic u2,
                       input logic br, input logic jr, input logic jl,
                       input logic req, input logic rdy);
    load_E = ld;  reg_dest_E = dest; rs1_D = r1; rs1_used_D = u1;
    rs2_D = r2;   rs2_used_D = u2;   br_E = br;  jalr_E = jr; jal_D = jl;
    mem_req_M = req; mem_ready = rdy;
  endtask

  task automatic idle_in();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called just after the falling edge with inputs already applied.
  task automatic step(input string tag, input logic [9:0] e1, input logic [9:0] e0);
    #1;
    chk({tag, "_ctl_h1"}, 32'(ctl1), 32'(e1));
    chk({tag, "_ctl_h0"}, 32'(ctl0), 32'(e0));
    @(posedge clk);
    #1;
    if (e1 == CTL_MEM || e1 == CTL_LU) es1++;
    if (e1 == CTL_BR  || e1 == CTL_JAL) ef1++;
    if (e0 == CTL_MEM || e0 == CTL_LU) es0++;
    if (e0 == CTL_BR  || e0 == CTL_JAL) ef0++;
    chk({tag, "_stall_h1"}, scnt1, es1);
    chk({tag, "_flush_h1"}, fcnt1, ef1);
    chk({tag, "_stall_h0"}, scnt0, es0);
    chk({tag, "_flush_h0"}, fcnt0, ef0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    es1 = 0; ef1 = 0; es0 = 0; ef0 = 0;
    #3;
    chk("rst_ctl_h1", 32'(ctl1), 32'(CTL_RST));
    chk("rst_ctl_h0", 32'(ctl0), 32'(CTL_RST));
    chk("rst_stall_h1", scnt1, 32'd0);
    chk("rst_flush_h0", fcnt0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    idle_in();                                                                    step("idle", CTL_NONE, CTL_NONE);
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_rs1", CTL_LU, CTL_LU);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_x0", CTL_NONE, CTL_NONE);
    drive(1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_rs2_unused", CTL_NONE, CTL_NONE);
    drive(1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_rs2", CTL_LU, CTL_LU);
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("br_over_lu", CTL_BR, CTL_BR);
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step("lu_over_jal", CTL_LU, CTL_LU);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step("jal", CTL_JAL, CTL_JAL);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step("jalr_over_jal", CTL_BR, CTL_BR);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); step("hit", CTL_NONE, CTL_NONE);

    // Miss: ready low for three cycles, then high. A branch during the miss is held off.
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step("miss_idle", CTL_MEM, CTL_MEM);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step("miss_1", CTL_MEM, CTL_MEM);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); step("miss_br", CTL_MEM, CTL_MEM);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); step("miss_ready", CTL_MEM, CTL_NONE);
    idle_in();                                                                    step("hold", CTL_MEM, CTL_NONE);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("br_after", CTL_BR, CTL_BR);

    // Back-to-back misses: second miss right after release of the first.
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step("b2b_a0", CTL_MEM, CTL_MEM);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); step("b2b_a1", CTL_MEM, CTL_NONE);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step("b2b_b0", CTL_MEM, CTL_MEM);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step("b2b_b1", CTL_MEM, CTL_MEM);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step("b2b_b2", CTL_MEM, CTL_NONE);

    // Reset mid-miss: h1 is in HOLD here and h0 has released.
    idle_in();
    rst_n = 1'b0;
    #1;
    chk("rstm_ctl_h1", 32'(ctl1), 32'(CTL_RST));
    chk("rstm_ctl_h0", 32'(ctl0), 32'(CTL_RST));
    chk("rstm_stall_h1", scnt1, 32'd0);
    chk("rstm_flush_h1", fcnt1, 32'd0);
    chk("rstm_stall_h0", scnt0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    es1 = 0; ef1 = 0; es0 = 0; ef0 = 0;
    step("post_rst", CTL_NONE, CTL_NONE);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step("post_rst_jal", CTL_JAL, CTL_JAL);

    // Stall counter wrap on h1.
    drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    force u_h1.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release u_h1.stall_cnt;
    es1 = 32'hFFFF_FFFF;
    step("wrap", CTL_LU, CTL_LU);
    idle_in();                                                                    step("end_idle", CTL_NONE, CTL_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
